// File: rtl/prio_enc_pkg.sv
// Shared constants and helpers for the priority / round-robin request encoder.
package prio_enc_pkg;

    localparam int MODE_FIXED = 0;
    localparam int MODE_RR    = 1;
    localparam int MAX_N      = 64;
    localparam int MAX_W      = 6;

    // Index of the highest set bit; 0 when the vector is empty.
    function automatic logic [MAX_W-1:0] highest_set(input logic [MAX_N-1:0] vec);
        logic [MAX_W-1:0] h;
        h = '0;
        for (int k = 0; k < MAX_N; k++) begin
            h = vec[k] ? MAX_W'(k) : h;
        end
        return h;
    endfunction

endpackage

// File: rtl/prio_search.sv
// Combinational circular search: the first set bit of req scanning down from
// base, wrapping modulo N (not modulo 2^W).
module prio_search
    import prio_enc_pkg::*;
#(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] base,
    output logic [W-1:0] idx,
    output logic         any
);

    localparam logic [W:0] N_EXT = (W+1)'(N);

    logic [2*N-1:0]   dbl_s;
    logic [N-1:0]     rot_s;
    logic [MAX_W-1:0] hi_s;
    logic [W:0]       sum_s;
    logic [W:0]       wrap_s;

    // Rotate so req[base] lands on the MSB, search, then map the hit back to req.
    always_comb begin
        dbl_s  = {req, req} >> ({1'b0, base} + (W+1)'(1));
        rot_s  = dbl_s[N-1:0];
        hi_s   = highest_set(MAX_N'(rot_s));
        sum_s  = {1'b0, base} + (W+1)'(hi_s) + (W+1)'(1);
        if (sum_s >= N_EXT) begin
            wrap_s = sum_s - N_EXT;
        end else begin
            wrap_s = sum_s;
        end
        any = |req;
        if (any) begin
            idx = wrap_s[W-1:0];
        end else begin
            idx = '0;
        end
    end

endmodule

// File: rtl/prio_rr_encoder.sv
// Registered N-to-log2(N) request encoder with valid/ack handshake and
// selectable fixed-priority or round-robin arbitration.
module prio_rr_encoder
    import prio_enc_pkg::*;
#(
    parameter int N    = 8,
    parameter int MODE = MODE_FIXED,
    localparam int W   = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         e,
    input  logic [N-1:0] i,
    input  logic         ack,
    output logic [W-1:0] y,
    output logic         v
);

    localparam logic [W-1:0] LAST = W'(N-1);

    logic [W-1:0] y_q, y_d;
    logic         v_q, v_d;
    logic [W-1:0] ptr_q, ptr_d;
    logic [W-1:0] base_s;
    logic [W-1:0] win_s;
    logic         any_s;
    logic         load_s;
    logic         accept_s;

    prio_search #(.N(N), .W(W)) u_search (
        .req  (i),
        .base (base_s),
        .idx  (win_s),
        .any  (any_s)
    );

    // Handshake, pointer advance and next-state selection.
    always_comb begin
        accept_s = v_q & ack;
        load_s   = e & (~v_q | ack);

        // A same-edge load must already see the pointer moved past the accepted grant.
        if ((MODE == MODE_RR) && accept_s) begin
            ptr_d = (y_q == '0) ? LAST : (y_q - W'(1));
        end else begin
            ptr_d = ptr_q;
        end

        if (MODE == MODE_RR) begin
            base_s = ptr_d;
        end else begin
            base_s = LAST;
        end

        y_d = y_q;
        v_d = v_q;
        if (load_s) begin
            v_d = any_s;
            y_d = win_s;
        end else if (accept_s) begin
            v_d = 1'b0;
        end else begin
            v_d = v_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            y_q   <= '0;
            v_q   <= 1'b0;
            ptr_q <= LAST;
        end else begin
            y_q   <= y_d;
            v_q   <= v_d;
            ptr_q <= ptr_d;
        end
    end

    assign y = y_q;
    assign v = v_q;

endmodule

// File: tb/tb_prio_rr_encoder.sv
// Self-checking bench: directed tables/sequences plus randomized traffic
// against a rule-level reference model, for fixed N=8, RR N=8 and RR N=5.
module tb_prio_rr_encoder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // DUT a: fixed priority, N=8
    logic       a_rst, a_e, a_ack, a_v;
    logic [7:0] a_i;
    logic [2:0] a_y;
    // DUT b: round robin, N=8
    logic       b_rst, b_e, b_ack, b_v;
    logic [7:0] b_i;
    logic [2:0] b_y;
    // DUT c: round robin, N=5
    logic       c_rst, c_e, c_ack, c_v;
    logic [4:0] c_i;
    logic [2:0] c_y;

    prio_rr_encoder #(.N(8), .MODE(0)) dut_a (
        .clk(clk), .rst(a_rst), .e(a_e), .i(a_i), .ack(a_ack), .y(a_y), .v(a_v));
    prio_rr_encoder #(.N(8), .MODE(1)) dut_b (
        .clk(clk), .rst(b_rst), .e(b_e), .i(b_i), .ack(b_ack), .y(b_y), .v(b_v));
    prio_rr_encoder #(.N(5), .MODE(1)) dut_c (
        .clk(clk), .rst(c_rst), .e(c_e), .i(c_i), .ack(c_ack), .y(c_y), .v(c_v));

    typedef struct {
        logic       e;
        logic       ack;
        logic [7:0] i;
        int         ey;
        logic       ev;
    } vec_t;

    vec_t tbl[12];

    // reference model state, one slot per DUT
    int m_y[3], m_v[3], m_p[3];
    int m_n[3]    = '{8, 8, 5};
    int m_mode[3] = '{0, 1, 1};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [2:0] ay, input logic av,
                         input int ey, input int ev);
        total++;
        if (ay !== 3'(ey) || av !== 1'(ev)) begin
            bad++;
            $display("FAIL %s: got y=%0d v=%0d, want y=%0d v=%0d", nm, ay, av, ey, ev);
        end
    endtask

    // First requester found scanning down from start, wrapping mod n.
    function automatic int ref_winner(input int n, input int req, input int start);
        for (int k = 0; k < n; k++) begin
            int idx;
            idx = (start - k + n) % n;
            if (req[idx]) return idx;
        end
        return 0;
    endfunction

    task automatic model_edge(input int k, input logic rst, input logic e,
                              input logic ack, input int req);
        int np;
        bit acc, ld;
        if (rst) begin
            m_y[k] = 0; m_v[k] = 0; m_p[k] = m_n[k] - 1;
        end else begin
            acc = (m_v[k] != 0) && ack;
            ld  = e && ((m_v[k] == 0) || ack);
            np  = m_p[k];
            if (m_mode[k] == 1 && acc) np = (m_y[k] == 0) ? m_n[k] - 1 : m_y[k] - 1;
            if (ld) begin
                m_v[k] = (req != 0) ? 1 : 0;
                m_y[k] = (req == 0) ? 0
                       : ref_winner(m_n[k], req, (m_mode[k] == 1) ? np : m_n[k] - 1);
            end else if (acc) begin
                m_v[k] = 0;
            end
            m_p[k] = np;
        end
    endtask

    initial begin
        int exp_b81[6] = '{7, 0, 7, 7, 0, 7};
        logic ack_b81[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        int exp_c[3] = '{4, 0, 4};

        tbl[0]  = '{1'b1, 1'b1, 8'h26, 5, 1'b1};
        tbl[1]  = '{1'b1, 1'b1, 8'h00, 0, 1'b0};
        tbl[2]  = '{1'b1, 1'b1, 8'h26, 5, 1'b1};
        tbl[3]  = '{1'b1, 1'b0, 8'h80, 5, 1'b1};
        tbl[4]  = '{1'b1, 1'b0, 8'h80, 5, 1'b1};
        tbl[5]  = '{1'b1, 1'b0, 8'h80, 5, 1'b1};
        tbl[6]  = '{1'b1, 1'b1, 8'h80, 7, 1'b1};
        tbl[7]  = '{1'b0, 1'b1, 8'h80, 7, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 8'hFF, 7, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 8'hFF, 7, 1'b0};
        tbl[10] = '{1'b1, 1'b0, 8'h01, 0, 1'b1};
        tbl[11] = '{1'b1, 1'b1, 8'h0C, 3, 1'b1};

        a_rst = 1'b1; a_e = 1'b0; a_ack = 1'b0; a_i = 8'h00;
        b_rst = 1'b1; b_e = 1'b0; b_ack = 1'b0; b_i = 8'h00;
        c_rst = 1'b1; c_e = 1'b0; c_ack = 1'b0; c_i = 5'h00;
        step();
        check("reset_a", a_y, a_v, 0, 0);
        check("reset_b", b_y, b_v, 0, 0);
        check("reset_c", c_y, c_v, 0, 0);
        a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;

        // fixed priority table
        for (int r = 0; r < 12; r++) begin
            a_e = tbl[r].e; a_ack = tbl[r].ack; a_i = tbl[r].i;
            step();
            check($sformatf("fixed_row%0d", r), a_y, a_v, tbl[r].ey, tbl[r].ev);
        end

        // round robin, all requesting
        b_i = 8'hFF; b_e = 1'b1; b_ack = 1'b1;
        for (int r = 0; r < 9; r++) begin
            step();
            check($sformatf("rr_ff_%0d", r), b_y, b_v, (r == 8) ? 7 : 7 - r, 1);
        end

        // round robin, two requesters with one stall
        b_rst = 1'b1; step(); b_rst = 1'b0;
        b_i = 8'h81;
        for (int r = 0; r < 6; r++) begin
            b_ack = ack_b81[r];
            step();
            check($sformatf("rr_81_%0d", r), b_y, b_v, exp_b81[r], 1);
        end

        // N=5 round robin with reset mid-grant
        c_i = 5'b10001; c_e = 1'b1; c_ack = 1'b1;
        for (int r = 0; r < 3; r++) begin
            step();
            check($sformatf("rr5_%0d", r), c_y, c_v, exp_c[r], 1);
        end
        c_rst = 1'b1;
        step();
        check("rr5_rst", c_y, c_v, 0, 0);
        c_rst = 1'b0;
        step();
        check("rr5_after_rst", c_y, c_v, 4, 1);

        // randomized traffic against the reference model
        a_rst = 1'b1; b_rst = 1'b1; c_rst = 1'b1;
        for (int k = 0; k < 3; k++) model_edge(k, 1'b1, 1'b0, 1'b0, 0);
        step();
        for (int cyc = 0; cyc < 600; cyc++) begin
            int req[3];
            logic rr[3], ee[3], aa[3];
            for (int k = 0; k < 3; k++) begin
                rr[k] = ($urandom_range(0, 49) == 0);
                ee[k] = ($urandom_range(0, 9) < 8);
                aa[k] = ($urandom_range(0, 9) < 7);
                case ($urandom_range(0, 3))
                    0:       req[k] = 1 << $urandom_range(0, m_n[k] - 1);
                    1:       req[k] = 0;
                    default: req[k] = int'($urandom) & ((1 << m_n[k]) - 1);
                endcase
            end
            a_rst = rr[0]; a_e = ee[0]; a_ack = aa[0]; a_i = 8'(req[0]);
            b_rst = rr[1]; b_e = ee[1]; b_ack = aa[1]; b_i = 8'(req[1]);
            c_rst = rr[2]; c_e = ee[2]; c_ack = aa[2]; c_i = 5'(req[2]);
            for (int k = 0; k < 3; k++) model_edge(k, rr[k], ee[k], aa[k], req[k]);
            step();
            check("rand_a", a_y, a_v, m_y[0], m_v[0]);
            check("rand_b", b_y, b_v, m_y[1], m_v[1]);
            check("rand_c", c_y, c_v, m_y[2], m_v[2]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/prio_rr_encoder.md
Name: prio_rr_encoder

Overview:
Parametrised N-to-log2(N) request encoder. Successor to the fixed 8-to-3 priority encoder, with a registered output, a valid/ack handshake and a selectable round-robin mode. It encodes the winning request index for downstream interrupt and arbitration logic. With MODE=0 it behaves like the 8-to-3 encoder: highest index wins, and the result is registered one cycle later.

Parameters:
N, 8, number of request lines; N >= 2; need not be a power of two.
W, $clog2(N), width of the encoded index; derived, not overridden.
MODE, 0, 0 = fixed priority (highest index wins); 1 = round-robin.

Ports:
clk  input  1  single clock, all state on the rising edge.
rst  input  1  synchronous, active-high reset.
e  input  1  enable; a new request vector is sampled only when e=1.
i  input  N  request vector; bit k = request from source k.
ack  input  1  consumer accepts the current y/v this cycle.
y  output  W  registered index of the winning request.
v  output  1  registered valid; 1 = y holds a valid grant.

Behaviour:
- Reset (rst=1 at a clock edge):
  - y=0, v=0, internal pointer ptr=N-1.
  - rst overrides every other input, including a pending ack or a mid-hold grant.
- Load condition: load = e & (~v | ack). On a load edge:
  - v <= |i.
  - y <= winning index, or 0 if i==0.
- Latency: exactly 1 cycle from sampling i to y/v. Throughput is one grant per cycle while ack=1.
- Hold: v=1 and ack=0 -> y and v hold; i is ignored.
- e=0 and v=1 and ack=1 -> v <= 0, y holds its value.
- e=0 and v=0 -> nothing changes.
- Outputs are never tri-state. There is no z output.
- MODE=0 winner: highest set bit of i. ptr is unused and stays N-1.
- MODE=1 winner: first set bit searched from ptr down to 0, then wrapping to N-1 and continuing down to ptr+1.
- MODE=1 pointer update: on an accepted grant (v=1 and ack=1 at an edge), ptr <= (y==0) ? N-1 : y-1. The just-served source becomes lowest priority.
  - ptr does not move without an accept.
  - ptr is reset to N-1, so the first RR grant matches fixed priority.
- Simultaneous accept and load in the same edge:
  - The winner for the new load is computed with the pointer value after this accept's update (next-ptr).
  - Guarantees a source granted and accepted is not re-granted back-to-back while another is requesting.
- Index arithmetic: all modulo N. For non-power-of-two N, wrap is N-1 -> 0 explicitly, never 2^W.
- Single request: always granted regardless of ptr, in both modes.
- y is always < N.

Decomposition:
- Shared package prio_enc_pkg:
  - MODE_FIXED=0 and MODE_RR=1 constants.
  - A function returning the highest set bit index of a vector (fixed search).
- Sub-module prio_search (combinational, parameters N and W):
  - Inputs: req[N-1:0], base[W-1:0].
  - Outputs: idx[W-1:0], any.
  - Rotates req so base maps to the MSB, does a fixed highest-bit search, then un-rotates modulo N.
  - MODE=0 ties base to N-1.
- The top level holds the y/v/ptr registers, the load/accept logic and next-ptr selection.

Test Plan:
- MODE=0, N=8, e=1, ack=1, i=8'b0010_0110 -> next cycle y=5, v=1; then i=8'h00 -> y=0, v=0.
- Backpressure: v=1, y=5, ack=0 for 3 cycles while i changes to 8'h80 -> y stays 5, v stays 1. Assert ack -> next cycle y=7.
- e=0 with v=1, ack=1 -> v=0, y unchanged. e=0, v=0, i=8'hFF -> v remains 0 for all cycles.
- MODE=1, N=8, i=8'hFF held, e=1, ack=1 every cycle -> y sequence 7,6,5,4,3,2,1,0,7 with v=1 throughout.
- MODE=1, i=8'b1000_0001 held, ack=1 -> y alternates 7,0,7,0. With ack=0 on one cycle -> that y repeats once and the alternation resumes.
- MODE=1, N=5, i=5'b10001, then rst asserted mid-sequence with v=1:
  - Before reset: y alternates 4,0.
  - Cycle after rst: y=0, v=0.
  - First grant after rst: y=4 (ptr=4).
